// File: rtl/sort_seq_pkg.sv
// sort_seq_pkg: shared state encoding and sizing helper for the sort job sequencer
package sort_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SORT_KICK,
    S_SORT_WAIT,
    S_UNLOAD_RD,
    S_UNLOAD_OUT,
    S_DONE,
    S_ERR
  } state_e;
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction
endpackage

// File: rtl/sort_seq_watchdog.sv
// sort_seq_watchdog: loadable up-counter with clear/enable; o_tc marks the cycle that reaches LIMIT
module sort_seq_watchdog #(
  parameter int W     = 13,
  parameter int LIMIT = 4096
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign o_tc  = cnt_q == W'(LIMIT - 1);
  assign cnt_d = i_clr ? '0 : i_load ? i_load_val : (i_en && !o_tc) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sort_job_sequencer.sv
// sort_job_sequencer: loads a job into RAM, hands the RAM to the sorter, then streams the sorted words out
module sort_job_sequencer
  import sort_seq_pkg::*;
#(
  parameter int SIZE_ADDR      = 4,
  parameter int SIZE_DATA      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_job_start,
  input  logic [SIZE_ADDR:0]   i_job_len,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [SIZE_DATA-1:0] i_in_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [SIZE_DATA-1:0] o_out_data,
  output logic                 o_sort_start,
  output logic [SIZE_ADDR-1:0] o_sort_num_elems,
  input  logic                 i_sort_done,
  output logic                 o_ram_owner,
  output logic [SIZE_ADDR-1:0] o_ram_addr,
  output logic                 o_ram_we,
  output logic [SIZE_DATA-1:0] o_ram_wdata,
  input  logic [SIZE_DATA-1:0] i_ram_rdata,
  output logic                 o_busy,
  output logic                 o_job_done,
  output logic                 o_error,
  output logic                 o_len_err
);
  localparam int DEPTH = depth_of(SIZE_ADDR);
  localparam int LW    = SIZE_ADDR + 1;
  localparam int WW    = $clog2(TIMEOUT_CYCLES + 1);
  state_e               state_q, state_d;
  logic [LW-1:0]        len_q, len_d, idx_q, idx_d;
  logic [SIZE_ADDR-1:0] num_q, num_d;
  logic [SIZE_DATA-1:0] out_q;
  logic                 first_q, done_prev_q, error_q, error_d, len_err_q, len_err_d;
  logic                 wd_clr, wd_en, wd_tc, last_idx, done_rise;
  assign last_idx  = idx_q == len_q - LW'(1);
  assign done_rise = i_sort_done && !done_prev_q;
  sort_seq_watchdog #(.W(WW), .LIMIT(TIMEOUT_CYCLES)) u_wd (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (wd_clr),
    .i_en       (wd_en),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_tc       (wd_tc)
  );
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    num_d     = num_q;
    error_d   = error_q;
    len_err_d = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    case (state_q)
      S_IDLE:
        if (i_job_start) begin
          if (i_job_len > LW'(DEPTH)) len_err_d = 1'b1;
          else if (i_job_len == '0) state_d = S_DONE;
          else begin
            len_d   = i_job_len;
            idx_d   = '0;
            num_d   = SIZE_ADDR'(i_job_len - LW'(1));
            state_d = S_LOAD;
          end
        end
      S_LOAD:
        if (i_in_valid) begin
          // index restarts at 0 for whichever phase follows the last beat
          idx_d = last_idx ? '0 : idx_q + LW'(1);
          if (last_idx) state_d = (len_q == LW'(1)) ? S_UNLOAD_RD : S_SORT_KICK;
        end
      S_SORT_KICK: begin
        idx_d   = '0;
        wd_clr  = 1'b1;
        state_d = S_SORT_WAIT;
      end
      S_SORT_WAIT: begin
        wd_en = 1'b1;
        if (done_rise) state_d = S_UNLOAD_RD;
        else if (wd_tc) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
      S_UNLOAD_RD: state_d = S_UNLOAD_OUT;
      S_UNLOAD_OUT:
        if (i_out_ready) begin
          state_d = last_idx ? S_DONE : S_UNLOAD_RD;
          idx_d   = last_idx ? idx_q : idx_q + LW'(1);
        end
      S_DONE: state_d = S_IDLE;
      S_ERR:
        if (i_job_start) begin
          error_d = 1'b0;
          state_d = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      out_q       <= '0;
      first_q     <= 1'b0;
      done_prev_q <= 1'b0;
      error_q     <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      first_q     <= state_q == S_UNLOAD_RD;
      done_prev_q <= i_sort_done;
      error_q     <= error_d;
      len_err_q   <= len_err_d;
      if (first_q) out_q <= i_ram_rdata;
    end
  // RAM data is live on the first UNLOAD_OUT cycle; afterwards the captured copy holds it steady
  assign o_out_data       = first_q ? i_ram_rdata : out_q;
  assign o_in_ready       = state_q == S_LOAD;
  assign o_ram_we         = state_q == S_LOAD && i_in_valid;
  assign o_ram_wdata      = o_ram_we ? i_in_data : '0;
  assign o_ram_addr       = (o_ram_we || state_q == S_UNLOAD_RD) ? idx_q[SIZE_ADDR-1:0] : '0;
  assign o_ram_owner      = state_q == S_SORT_KICK || state_q == S_SORT_WAIT;
  assign o_sort_start     = state_q == S_SORT_KICK;
  assign o_sort_num_elems = num_q;
  assign o_out_valid      = state_q == S_UNLOAD_OUT;
  assign o_busy           = state_q != S_IDLE;
  assign o_job_done       = state_q == S_DONE;
  assign o_error          = error_q;
  assign o_len_err        = len_err_q;
endmodule

// File: tb/tb_sort_job_sequencer.sv
// tb_sort_job_sequencer: job table plus timeout/stale-done/reset sequences, RAM and sorter modelled here
module tb_sort_job_sequencer;
  logic       clk = 0, rst_n = 0;
  logic       i_job_start = 0, i_in_valid = 0, i_out_ready = 1, i_sort_done = 0;
  logic [4:0] i_job_len = 0;
  logic [7:0] i_in_data = 0, ram_rdata = 0;
  logic       o_in_ready, o_out_valid, o_sort_start, o_ram_owner, o_ram_we, o_busy, o_job_done, o_error, o_len_err;
  logic [7:0] o_out_data, o_ram_wdata;
  logic [3:0] o_sort_num_elems, o_ram_addr;
  sort_job_sequencer #(.SIZE_ADDR(4), .SIZE_DATA(8), .TIMEOUT_CYCLES(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_job_start(i_job_start), .i_job_len(i_job_len),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_sort_start(o_sort_start), .o_sort_num_elems(o_sort_num_elems), .i_sort_done(i_sort_done),
    .o_ram_owner(o_ram_owner), .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we), .o_ram_wdata(o_ram_wdata),
    .i_ram_rdata(ram_rdata), .o_busy(o_busy), .o_job_done(o_job_done), .o_error(o_error), .o_len_err(o_len_err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int n_start = 0, n_we = 0, n_lenerr = 0, n_done = 0;
  int ks_cyc = 0, done_cyc = 0, last_hs_cyc = 0, first_out_cyc = -1;
  int last_num = 0, sort_req = 0, sort_ack = 0, sort_n = 1;
  int sort_mode = 0, drop_dly = 1, rise_dly = 4, ready_mode = 0;
  logic [7:0] mem [16];
  logic [7:0] tmp [16];
  logic [7:0] exp_q [$];
  logic       hold_prev = 0;
  logic [7:0] prev_data = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // single-port RAM with one-cycle read latency; the sorter model reorders it in place
  always @(posedge clk) begin
    if (sort_req != sort_ack) begin
      tmp = mem;
      for (int i = 0; i < sort_n; i++)
        for (int j = 0; j + 1 < sort_n - i; j++)
          if (tmp[j] > tmp[j+1]) begin
            logic [7:0] t;
            t = tmp[j]; tmp[j] = tmp[j+1]; tmp[j+1] = t;
          end
      mem <= tmp;
      sort_ack <= sort_req;
    end else if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
    ram_rdata <= mem[o_ram_addr];
  end
  initial forever begin
    @(negedge clk);
    if (rst_n && o_sort_start === 1'b1) begin
      sort_n = int'(o_sort_num_elems) + 1;
      @(posedge clk);
      if (sort_mode == 1) begin
        #1 i_sort_done = 0;
      end else begin
        repeat (drop_dly - 1) @(posedge clk);
        #1 i_sort_done = 0;
        repeat (rise_dly - 1) @(posedge clk);
        #1 sort_req++;
        @(posedge clk);
        #1 i_sort_done = 1;
      end
    end
  end
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1 i_out_ready = (ready_mode == 0) || (ph == 0);
      ph = (ph + 1) % 3;
    end
  end
  always @(negedge clk) if (rst_n) begin
    if (o_sort_start) begin n_start++; last_num = int'(o_sort_num_elems); ks_cyc = cyc; end
    if (o_ram_we) begin n_we++; chk("we_while_sorter_owns", o_ram_owner, 0); end
    if (o_len_err) n_lenerr++;
    if (o_job_done) begin n_done++; done_cyc = cyc; end
    if (o_out_valid) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      chk("in_ready_during_unload", o_in_ready, 0);
      if (hold_prev) chk("out_data_stable", o_out_data, prev_data);
      if (i_out_ready) begin
        last_hs_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_unexpected: got %0h expected no output", o_out_data);
        end else chk("out_data", o_out_data, exp_q.pop_front());
      end
    end
    hold_prev = o_out_valid && !i_out_ready;
    prev_data = o_out_data;
  end
  function automatic void push_sorted(input logic [7:0] d[$]);
    logic [7:0] s[$];
    s = d;
    for (int i = 1; i < s.size(); i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        logic [7:0] t;
        t = s[j]; s[j] = s[j-1]; s[j-1] = t;
      end
    foreach (s[i]) exp_q.push_back(s[i]);
  endfunction
  task automatic start_job(input int len);
    @(posedge clk);
    #1 i_job_start = 1; i_job_len = 5'(len);
    @(posedge clk);
    #1 i_job_start = 0;
  endtask
  task automatic load(input logic [7:0] d[$]);
    foreach (d[i]) begin
      int t = 0;
      i_in_valid = 1; i_in_data = d[i];
      @(negedge clk);
      while (!o_in_ready && t < 50) begin @(negedge clk); t++; end
      chk("in_ready_seen", o_in_ready, 1);
      @(posedge clk);
      #1;
    end
    i_in_valid = 0;
  endtask
  function automatic void make_data(input int len, input int pat, output logic [7:0] d[$]);
    d = {};
    for (int i = 0; i < len && i < 16; i++)
      d.push_back(pat == 0 ? 8'(len - 1 - i) : pat == 2 ? 8'hA5 : 8'($urandom_range(0, 255)));
  endfunction
  typedef struct {
    int len; int pat; int rdy;
    int exp_starts; int exp_num; int exp_lenerr; int exp_done; int exp_we;
  } vec_t;
  vec_t tbl [7];
  task automatic run_vec(input vec_t v);
    logic [7:0] d[$];
    int s0 = n_start, w0 = n_we, e0 = n_lenerr, d0 = n_done, st, t = 0;
    ready_mode = v.rdy;
    first_out_cyc = -1;
    make_data(v.len, v.pat, d);
    if (v.len >= 1 && v.len <= 16) push_sorted(d);
    start_job(v.len);
    st = cyc - 1;
    if (v.len >= 1 && v.len <= 16) load(d);
    while (n_done == d0 && n_lenerr == e0 && t < 3000) begin
      @(negedge clk); t++;
      if (v.exp_lenerr != 0) chk("busy_on_len_err", o_busy, 0);
    end
    chk("job_end_seen", t < 3000, 1);
    if (v.exp_lenerr != 0) repeat (3) begin @(negedge clk); chk("busy_after_len_err", o_busy, 0); end
    chk("sort_starts", n_start - s0, v.exp_starts);
    if (v.exp_starts != 0) begin
      chk("sort_num_elems", last_num, v.exp_num);
      chk("sort_latency", first_out_cyc - ks_cyc, drop_dly + rise_dly + 2);
    end
    chk("len_err_pulses", n_lenerr - e0, v.exp_lenerr);
    chk("job_done_pulses", n_done - d0, v.exp_done);
    chk("ram_writes", n_we - w0, v.exp_we);
    chk("outputs_drained", exp_q.size(), 0);
    if (v.exp_done != 0 && v.len == 0) chk("len0_done_cycle", done_cyc - st, 1);
    if (v.exp_done != 0 && v.len > 0) chk("done_after_last_hs", done_cyc - last_hs_cyc, 1);
    exp_q.delete();
  endtask
  function automatic logic [31:0] all_outs();
    return {o_busy, o_ram_owner, o_out_valid, o_in_ready, o_error, o_sort_start, o_ram_we,
            o_job_done, o_len_err, o_ram_addr, o_out_data, o_sort_num_elems, o_ram_wdata} != 0;
  endfunction
  initial begin
    logic [7:0] d[$];
    int t;
    tbl[0] = '{16, 0, 0, 1, 15, 0, 1, 16};
    tbl[1] = '{4, 1, 1, 1, 3, 0, 1, 4};
    tbl[2] = '{0, 1, 0, 0, 0, 0, 1, 0};
    tbl[3] = '{1, 2, 0, 0, 0, 0, 1, 1};
    tbl[4] = '{17, 1, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{7, 1, 1, 1, 6, 0, 1, 7};
    tbl[6] = '{2, 0, 0, 1, 1, 0, 1, 2};
    foreach (mem[i]) mem[i] = 0;
    #12 chk("reset_outputs", all_outs(), 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);
    // prior job left done high; only a fresh rise may end SORT_WAIT
    chk("done_left_high", i_sort_done, 1);
    drop_dly = 3; rise_dly = 20;
    run_vec('{5, 1, 0, 1, 4, 0, 1, 5});
    drop_dly = 1; rise_dly = 4;
    sort_mode = 1;
    make_data(3, 1, d);
    start_job(3);
    load(d);
    t = 0;
    while (!o_error && t < 100) begin @(negedge clk); t++; end
    chk("error_raised", o_error, 1);
    chk("timeout_cycles", cyc - ks_cyc, 33);
    chk("err_owner", o_ram_owner, 0);
    chk("err_busy", o_busy, 1);
    repeat (5) @(negedge clk);
    chk("error_sticky", o_error, 1);
    start_job(5);
    @(negedge clk);
    chk("error_cleared", o_error, 0);
    chk("idle_after_err", o_busy, 0);
    chk("start_consumed", o_in_ready, 0);
    sort_mode = 0; rise_dly = 30;
    make_data(6, 1, d);
    t = n_start;
    start_job(6);
    load(d);
    repeat (4) @(negedge clk);
    chk("in_sort_wait", o_ram_owner, 1);
    #2 rst_n = 0;
    #1 chk("async_reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    chk("idle_in_reset", o_busy, 0);
    rst_n = 1;
    repeat (40) @(negedge clk);
    rise_dly = 4;
    chk("idle_after_reset", o_busy, 0);
    run_vec('{8, 1, 0, 1, 7, 0, 1, 8});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
